// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants, ERR bit indices, monitor FSM encoding and saturating-count helper
package vga_pkg;
  localparam int VGA_H_PIXELS = 800;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_DISP   = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_LINES  = 525;
  localparam int VGA_V_DISP   = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int ERR_LINE     = 0;
  localparam int ERR_HSW      = 1;
  localparam int ERR_FRAME    = 2;
  localparam int ERR_AWIDTH   = 3;
  localparam int ERR_AHEIGHT  = 4;
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return &v ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_edge_meter.sv
// vga_edge_meter: registered sync sample, fall/rise pulses and saturating low-width counter
module vga_edge_meter
  import vga_pkg::*;
(
  input  logic       VGA_CLK,
  input  logic       RESET,
  input  logic       sig,
  output logic       fall,
  output logic       rise,
  output logic [9:0] low_cnt
);
  logic prev;
  assign fall = prev & ~sig;
  assign rise = ~prev & sig;
  // low_cnt equals the completed low width in the cycle rise is asserted
  always_ff @(posedge VGA_CLK or posedge RESET)
    if (RESET) begin
      prev    <= 1'b1;
      low_cnt <= '0;
    end else begin
      prev    <= sig;
      low_cnt <= sig ? '0 : sat_inc(low_cnt);
    end
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers pixel coordinates, measures line/frame timing, locks and checksums VGA frames
module vga_timing_monitor
  import vga_pkg::*;
#(
  parameter int H_PIXELS    = VGA_H_PIXELS,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_DISP      = VGA_H_DISP,
  parameter int V_LINES     = VGA_V_LINES,
  parameter int V_DISP      = VGA_V_DISP,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        VGA_CLK,
  input  logic        RESET,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        ERR_CLR,
  output logic [9:0]  PIX_X,
  output logic [9:0]  PIX_Y,
  output logic        PIX_VALID,
  output logic        FRAME_START,
  output logic        LOCKED,
  output logic [9:0]  H_MEAS,
  output logic [9:0]  V_MEAS,
  output logic [31:0] FRAME_SUM,
  output logic [4:0]  ERR
);
  localparam logic [9:0] HP = 10'(H_PIXELS);
  localparam logic [9:0] HW = 10'(H_SYNC);
  localparam logic [9:0] HD = 10'(H_DISP);
  localparam logic [9:0] VL = 10'(V_LINES);
  localparam logic [9:0] VD = 10'(V_DISP);
  localparam logic [2:0] LF = 3'(LOCK_FRAMES);
  logic        hs_fall, hs_rise, vs_fall, unused_vs_rise;
  logic [9:0]  hs_w, unused_vs_w;
  logic [9:0]  h_cnt, v_cnt, a_cnt, l_cnt, h_len, v_len, a_lines, pix;
  logic        vs_pend, fs, a_line, chk, clean;
  logic [31:0] acc, acc_nxt;
  logic [4:0]  err_now;
  logic [1:0]  state, st_n;
  logic [2:0]  good, good_n;
  vga_edge_meter u_hs (
    .VGA_CLK(VGA_CLK), .RESET(RESET), .sig(VGA_HS),
    .fall(hs_fall), .rise(hs_rise), .low_cnt(hs_w)
  );
  vga_edge_meter u_vs (
    .VGA_CLK(VGA_CLK), .RESET(RESET), .sig(VGA_VS),
    .fall(vs_fall), .rise(unused_vs_rise), .low_cnt(unused_vs_w)
  );
  // a VS fall coinciding with an HS fall starts the frame at that HS fall
  assign fs      = hs_fall & (vs_pend | vs_fall);
  assign h_len   = sat_inc(h_cnt);
  assign v_len   = sat_inc(v_cnt);
  assign a_line  = a_cnt != '0;
  assign a_lines = a_line ? sat_inc(l_cnt) : l_cnt;
  assign pix     = {2'b0, VGA_R} + {2'b0, VGA_G} + {2'b0, VGA_B};
  assign acc_nxt = acc + {22'b0, VGA_BLANK_N ? pix : 10'd0};
  assign chk     = state != ST_SEARCH;
  assign err_now = chk ? {fs && a_lines != VD,
                          hs_fall && a_line && a_cnt != HD,
                          fs && v_len != VL,
                          hs_rise && hs_w != HW,
                          hs_fall && h_len != HP} : 5'd0;
  assign clean   = ~|err_now;
  assign good_n  = (state == ST_ALIGN && clean) ? good + {2'b0, fs} : 3'd0;
  assign st_n    = state == ST_SEARCH ? (fs ? ST_ALIGN : ST_SEARCH)
                 : state == ST_ALIGN  ? ((clean && fs && good_n == LF) ? ST_LOCKED : ST_ALIGN)
                 : (clean ? ST_LOCKED : ST_SEARCH);
  always_ff @(posedge VGA_CLK or posedge RESET)
    if (RESET) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      a_cnt       <= '0;
      l_cnt       <= '0;
      vs_pend     <= 1'b0;
      acc         <= '0;
      state       <= ST_SEARCH;
      good        <= '0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      PIX_VALID   <= 1'b0;
      FRAME_START <= 1'b0;
      LOCKED      <= 1'b0;
      H_MEAS      <= '0;
      V_MEAS      <= '0;
      FRAME_SUM   <= '0;
      ERR         <= '0;
    end else begin
      h_cnt       <= hs_fall ? '0 : sat_inc(h_cnt);
      a_cnt       <= hs_fall ? '0 : VGA_BLANK_N ? sat_inc(a_cnt) : a_cnt;
      v_cnt       <= fs ? '0 : hs_fall ? v_len : v_cnt;
      l_cnt       <= fs ? '0 : hs_fall ? a_lines : l_cnt;
      vs_pend     <= fs ? 1'b0 : vs_pend | vs_fall;
      acc         <= fs ? '0 : acc_nxt;
      H_MEAS      <= hs_fall ? h_len : H_MEAS;
      V_MEAS      <= fs ? v_len : V_MEAS;
      FRAME_SUM   <= fs ? acc_nxt : FRAME_SUM;
      FRAME_START <= fs;
      ERR         <= (ERR_CLR ? 5'd0 : ERR) | err_now;
      state       <= st_n;
      good        <= good_n;
      LOCKED      <= st_n == ST_LOCKED;
      PIX_VALID   <= VGA_BLANK_N & LOCKED;
      PIX_X       <= (VGA_BLANK_N && LOCKED) ? a_cnt : PIX_X;
      PIX_Y       <= (VGA_BLANK_N && LOCKED) ? l_cnt : PIX_Y;
    end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed scenarios on a scaled 80x16 mode (48x10 active, HS 8 clocks at h=56, VS on lines 12-13)
module tb_vga_timing_monitor;
  localparam int HP = 80, HSW = 8, HD = 48, VL = 16, VD = 10, HSS = 56, VSS = 12;
  logic VGA_CLK = 1'b0, RESET = 1'b1, VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_BLANK_N = 1'b0, ERR_CLR = 1'b0;
  logic [7:0] VGA_R = 8'd0, VGA_G = 8'd0, VGA_B = 8'd0;
  logic [9:0] PIX_X, PIX_Y, H_MEAS, V_MEAS;
  logic PIX_VALID, FRAME_START, LOCKED;
  logic [31:0] FRAME_SUM;
  logic [4:0] ERR;
  int tests = 0, fails = 0;
  int gv = 0, gh = 0, cur_len = HP, cur_sw = HSW;
  int fs_seen = 0, lock_fs = 0, base = 0;
  logic lk_d = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;
  vga_timing_monitor #(
    .H_PIXELS(HP), .H_SYNC(HSW), .H_DISP(HD), .V_LINES(VL), .V_DISP(VD), .LOCK_FRAMES(2)
  ) dut (
    .VGA_CLK(VGA_CLK), .RESET(RESET), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .ERR_CLR(ERR_CLR),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_VALID(PIX_VALID), .FRAME_START(FRAME_START), .LOCKED(LOCKED),
    .H_MEAS(H_MEAS), .V_MEAS(V_MEAS), .FRAME_SUM(FRAME_SUM), .ERR(ERR)
  );
  // frame-start count at the moment LOCKED rises
  always @(negedge VGA_CLK) begin
    fs_seen <= fs_seen + int'(FRAME_START);
    if (LOCKED && !lk_d) lock_fs <= fs_seen + int'(FRAME_START);
    lk_d <= LOCKED;
  end
  task automatic drive(input logic hs, input logic vs, input logic bl);
    @(negedge VGA_CLK);
    VGA_HS = hs;
    VGA_VS = vs;
    VGA_BLANK_N = bl;
    {VGA_R, VGA_G, VGA_B} = bl ? 24'h010203 : 24'h000000;
    @(posedge VGA_CLK);
    #1;
  endtask
  task automatic step();
    drive(!(gh >= HSS && gh < HSS + cur_sw), !(gv >= VSS && gv < VSS + 2), gv < VD && gh < HD);
    gh++;
    if (gh == cur_len) begin
      gh = 0;
      gv = (gv + 1) % VL;
      cur_len = HP;
      cur_sw = HSW;
    end
  endtask
  task automatic go(input int v, input int h);
    for (int n = 0; n < 3000 && !(gv == v && gh == h); n++) step();
  endtask
  task automatic next_fs();
    go(VSS, HSS);
    step();
  endtask
  task automatic relock(input string tag);
    next_fs();
    next_fs();
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL %s_early got=%0d exp=0", tag, LOCKED); end
    next_fs();
    tests++; if (LOCKED !== 1'b1) begin fails++; $display("FAIL %s_relock got=%0d exp=1", tag, LOCKED); end
  endtask
  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge VGA_CLK);
    #1;
    tests++; if ({PIX_X, PIX_Y, PIX_VALID, FRAME_START, LOCKED} !== 23'd0) begin fails++; $display("FAIL reset_pix got=%h exp=0", {PIX_X, PIX_Y, PIX_VALID, FRAME_START, LOCKED}); end
    tests++; if ({H_MEAS, V_MEAS, FRAME_SUM, ERR} !== 57'd0) begin fails++; $display("FAIL reset_meas got=%h exp=0", {H_MEAS, V_MEAS, FRAME_SUM, ERR}); end
    @(negedge VGA_CLK);
    RESET = 1'b0;
  endtask
  task automatic test_lock();
    base = fs_seen;
    next_fs();
    tests++; if (FRAME_START !== 1'b1) begin fails++; $display("FAIL fs_pulse got=%0d exp=1", FRAME_START); end
    step();
    tests++; if (FRAME_START !== 1'b0) begin fails++; $display("FAIL fs_one_clock got=%0d exp=0", FRAME_START); end
    next_fs();
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL lock_early got=%0d exp=0", LOCKED); end
    tests++; if (FRAME_SUM !== 32'd2880) begin fails++; $display("FAIL sum_first got=%0d exp=2880", FRAME_SUM); end
    next_fs();
    tests++; if (LOCKED !== 1'b1) begin fails++; $display("FAIL lock got=%0d exp=1", LOCKED); end
    tests++; if (H_MEAS !== 10'd80) begin fails++; $display("FAIL h_meas got=%0d exp=80", H_MEAS); end
    tests++; if (V_MEAS !== 10'd16) begin fails++; $display("FAIL v_meas got=%0d exp=16", V_MEAS); end
    tests++; if (ERR !== 5'd0) begin fails++; $display("FAIL err_clean got=%b exp=00000", ERR); end
    tests++; if (FRAME_SUM !== 32'd2880) begin fails++; $display("FAIL frame_sum got=%0d exp=2880", FRAME_SUM); end
    step();
    tests++; if (lock_fs - base !== 3) begin fails++; $display("FAIL lock_at_fs got=%0d exp=3", lock_fs - base); end
  endtask
  task automatic test_pixels();
    go(0, 0);
    step();
    tests++; if ({PIX_VALID, PIX_X, PIX_Y} !== {1'b1, 10'd0, 10'd0}) begin fails++; $display("FAIL first_pixel got=%0d,%0d,%0d exp=1,0,0", PIX_VALID, PIX_X, PIX_Y); end
    go(3, 5);
    step();
    tests++; if ({PIX_X, PIX_Y} !== {10'd5, 10'd3}) begin fails++; $display("FAIL mid_pixel got=%0d,%0d exp=5,3", PIX_X, PIX_Y); end
    go(VD - 1, HD - 1);
    step();
    tests++; if ({PIX_VALID, PIX_X, PIX_Y} !== {1'b1, 10'd47, 10'd9}) begin fails++; $display("FAIL last_pixel got=%0d,%0d,%0d exp=1,47,9", PIX_VALID, PIX_X, PIX_Y); end
    step();
    tests++; if ({PIX_VALID, PIX_X, PIX_Y} !== {1'b0, 10'd47, 10'd9}) begin fails++; $display("FAIL pixel_hold got=%0d,%0d,%0d exp=0,47,9", PIX_VALID, PIX_X, PIX_Y); end
  endtask
  task automatic test_line_stretch();
    go(2, 0);
    cur_len = HP + 1;
    go(3, HSS);
    tests++; if (LOCKED !== 1'b1) begin fails++; $display("FAIL stretch_pre got=%0d exp=1", LOCKED); end
    step();
    tests++; if (H_MEAS !== 10'd81) begin fails++; $display("FAIL stretch_h got=%0d exp=81", H_MEAS); end
    tests++; if (ERR !== 5'b00001) begin fails++; $display("FAIL stretch_err got=%b exp=00001", ERR); end
    tests++; if (LOCKED !== 1'b0) begin fails++; $display("FAIL stretch_unlock got=%0d exp=0", LOCKED); end
    relock("stretch");
  endtask
  task automatic test_hs_short();
    go(4, 0);
    cur_sw = HSW - 1;
    go(4, HSS + HSW - 1);
    step();
    tests++; if (ERR !== 5'b00011) begin fails++; $display("FAIL hs_short_err got=%b exp=00011", ERR); end
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    tests++; if (ERR !== 5'd0) begin fails++; $display("FAIL err_clr got=%b exp=00000", ERR); end
    relock("hs_short");
    tests++; if (ERR !== 5'd0) begin fails++; $display("FAIL err_stays_clear got=%b exp=00000", ERR); end
  endtask
  task automatic test_clr_collision();
    go(5, 0);
    cur_sw = HSW - 1;
    go(5, HSS + HSW - 1);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    tests++; if (ERR !== 5'b00010) begin fails++; $display("FAIL clr_collision got=%b exp=00010", ERR); end
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    relock("collision");
  endtask
  task automatic test_saturation();
    go(6, 0);
    repeat (1100) drive(1'b1, 1'b1, 1'b0);
    go(6, HSS);
    step();
    tests++; if (H_MEAS !== 10'd1023) begin fails++; $display("FAIL h_sat got=%0d exp=1023", H_MEAS); end
    tests++; if (ERR !== 5'b00001) begin fails++; $display("FAIL h_sat_err got=%b exp=00001", ERR); end
    go(7, HSS);
    step();
    tests++; if (H_MEAS !== 10'd80) begin fails++; $display("FAIL h_after_sat got=%0d exp=80", H_MEAS); end
    relock("saturation");
  endtask
  task automatic test_async_reset();
    go(3, 20);
    step();
    tests++; if ({LOCKED, PIX_VALID} !== 2'b11) begin fails++; $display("FAIL areset_pre got=%b exp=11", {LOCKED, PIX_VALID}); end
    #2 RESET = 1'b1;
    #1;
    tests++; if ({PIX_X, PIX_Y, PIX_VALID, FRAME_START, LOCKED} !== 23'd0) begin fails++; $display("FAIL areset_pix got=%h exp=0", {PIX_X, PIX_Y, PIX_VALID, FRAME_START, LOCKED}); end
    tests++; if ({H_MEAS, V_MEAS, FRAME_SUM, ERR} !== 57'd0) begin fails++; $display("FAIL areset_meas got=%h exp=0", {H_MEAS, V_MEAS, FRAME_SUM, ERR}); end
    RESET = 1'b0;
    base = fs_seen;
    relock("areset");
    step();
    tests++; if (lock_fs - base !== 3) begin fails++; $display("FAIL areset_lock_fs got=%0d exp=3", lock_fs - base); end
    tests++; if (ERR !== 5'd0) begin fails++; $display("FAIL areset_err got=%b exp=00000", ERR); end
  endtask
  initial begin
    test_reset();
    test_lock();
    test_pixels();
    test_line_stretch();
    test_hs_short();
    test_clr_collision();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
